mult_div_unit: RTL and testbench

Parametrised multiply/divide unit for the P6-generation pipeline, sitting in the EX stage next to the ALU and owning the HI/LO registers. It executes mult/multu/div/divu with configurable multi-cycle latencies, handles mthi/mtlo as single-cycle writes, and optionally supports accumulate (madd/maddu/msub/msubu). It exports a `busy` flag; decode uses `busy`/`start` together with its `Multiply_D`/`Divide_D` style signals to stall md-dependent instructions.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_result_calc.sv | 103 ++++++++++
 rtl/mult_div_unit.sv | 126 ++++++++++++
 tb/tb_mult_div_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: operation codes, FSM state encoding and counter sizing
// shared by mult_div_unit and mdu_result_calc.
package mdu_pkg;

    // 4-bit md operation codes presented on mult_div_unit.op
    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_t;

    // Counter must hold the larger of the two latencies.
    function automatic int cnt_width(input int mul_cyc, input int div_cyc);
        int m;
        m = (mul_cyc > div_cyc) ? mul_cyc : div_cyc;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mdu_result_calc.sv
// mdu_result_calc: combinational next-{hi,lo} for the latched md op.
// Ports: i_op/i_a/i_b latched op and operands, i_hi/i_lo current
// HI/LO; o_hi/o_lo the value HI/LO take at the completion edge.
// Accumulate ops are present only when MDU_MADD_EN is defined.
module mdu_result_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    w_sprod;
    logic [PW-1:0]    w_uprod;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_b_mag_safe;
    logic [WIDTH-1:0] w_b_safe;
    logic [WIDTH-1:0] w_sq_mag;
    logic [WIDTH-1:0] w_sr_mag;
    logic [WIDTH-1:0] w_sq;
    logic [WIDTH-1:0] w_sr;
    logic [WIDTH-1:0] w_uq;
    logic [WIDTH-1:0] w_ur;

    // Sign-extending to 2*WIDTH makes the truncated unsigned product
    // equal to the two's-complement signed product.
    assign w_sprod = {{WIDTH{i_a[WIDTH-1]}}, i_a}
                   * {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_uprod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    // Signed divide via magnitudes; quotient truncates toward zero,
    // remainder follows the dividend. MIN/-1 wraps to MIN, rem 0.
    assign w_a_neg      = i_a[WIDTH-1];
    assign w_b_neg      = i_b[WIDTH-1];
    assign w_b_zero     = (i_b == '0);
    assign w_a_mag      = w_a_neg ? -i_a : i_a;
    assign w_b_mag      = w_b_neg ? -i_b : i_b;
    // Zero divisors are replaced so the dividers never see /0;
    // the result is discarded in that case anyway.
    assign w_b_mag_safe = w_b_zero ? WIDTH'(1) : w_b_mag;
    assign w_b_safe     = w_b_zero ? WIDTH'(1) : i_b;
    assign w_sq_mag     = w_a_mag / w_b_mag_safe;
    assign w_sr_mag     = w_a_mag % w_b_mag_safe;
    assign w_sq         = (w_a_neg ^ w_b_neg) ? -w_sq_mag : w_sq_mag;
    assign w_sr         = w_a_neg ? -w_sr_mag : w_sr_mag;
    assign w_uq         = i_a / w_b_safe;
    assign w_ur         = i_a % w_b_safe;

`ifdef MDU_MADD_EN
    logic [PW-1:0] w_acc;
    logic [PW-1:0] w_madd;
    logic [PW-1:0] w_maddu;
    logic [PW-1:0] w_msub;
    logic [PW-1:0] w_msubu;

    assign w_acc   = {i_hi, i_lo};
    assign w_madd  = w_acc + w_sprod;
    assign w_maddu = w_acc + w_uprod;
    assign w_msub  = w_acc - w_sprod;
    assign w_msubu = w_acc - w_uprod;
`endif

    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        case (i_op)
            OP_MULT:  {o_hi, o_lo} = w_sprod;
            OP_MULTU: {o_hi, o_lo} = w_uprod;
            OP_DIV: begin
                if (!w_b_zero) begin
                    o_lo = w_sq;
                    o_hi = w_sr;
                end
            end
            OP_DIVU: begin
                if (!w_b_zero) begin
                    o_lo = w_uq;
                    o_hi = w_ur;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {o_hi, o_lo} = w_madd;
            OP_MADDU: {o_hi, o_lo} = w_maddu;
            OP_MSUB:  {o_hi, o_lo} = w_msub;
            OP_MSUBU: {o_hi, o_lo} = w_msubu;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: EX-stage multiply/divide unit owning HI/LO.
// Ports: clk; reset (sync, active-low); start/op/a/b issue an md op;
// hi/lo registers; busy while a multi-cycle op is in flight.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mdu_state_t       r_state;
    mdu_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_is_acc;
    logic             w_go;
    logic             w_cap;

    assign w_is_mul = start && ((op == OP_MULT) || (op == OP_MULTU));
    assign w_is_div = start && ((op == OP_DIV) || (op == OP_DIVU));
`ifdef MDU_MADD_EN
    assign w_is_acc = start && ((op == OP_MADD) || (op == OP_MADDU) ||
                                (op == OP_MSUB) || (op == OP_MSUBU));
`else
    assign w_is_acc = 1'b0;
`endif
    assign w_go = w_is_mul || w_is_div || w_is_acc;

    mdu_result_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .i_hi (r_hi),
        .i_lo (r_lo),
        .o_hi (w_res_hi),
        .o_lo (w_res_lo)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_cap       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = w_is_div ? DIV_LAT : MUL_LAT;
                    w_cap       = 1'b1;
                end else if (start && (op == OP_MTHI)) begin
                    w_hi_nxt = a;
                end else if (start && (op == OP_MTLO)) begin
                    w_lo_nxt = a;
                end
            end
            S_BUSY: begin
                // New starts are dropped here; decode stalls on busy.
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = S_IDLE;
                    w_hi_nxt    = w_res_hi;
                    w_lo_nxt    = w_res_lo;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (w_cap) begin
                r_op <= op;
                r_a  <= a;
                r_b  <= b;
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state == S_BUSY);

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit
// with default parameters (5 mult cycles, 10 div cycles).
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc;

    always #5 clk = ~clk;

    mult_div_unit #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op for a single edge, then scramble operands so
    // any late sampling by the DUT shows up in the result.
    task automatic issue(input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = 4'hF;
        a     = 32'hA5A5_A5A5;
        b     = 32'h5A5A_5A5A;
    endtask

    // Busy cycles remaining from now; bounded so a stuck busy fails.
    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 4'h0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        reset = 1'b1;

        issue(OP_MULT, 32'hFFFF_FFFF, 32'h2);
        wait_done(cyc);
        chk("mult_cyc", cyc, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        // Issued in the cycle busy fell: back-to-back, no bubble.
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
        chk("multu_busy", {31'b0, busy}, 32'h1);
        wait_done(cyc);
        chk("multu_cyc", cyc, 32'd5);
        chk("multu_hi", hi, 32'h1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'h2);
        wait_done(cyc);
        chk("div_cyc", cyc, 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        chk("divmin_lo", lo, 32'h8000_0000);
        chk("divmin_hi", hi, 32'h0);

        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(cyc);
        chk("divu_cyc", cyc, 32'd10);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        issue(OP_MTHI, 32'h1234, 32'h0);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_busy", {31'b0, busy}, 32'h0);
        issue(OP_MTLO, 32'h5678, 32'h0);
        chk("mtlo_lo", lo, 32'h5678);
        chk("mtlo_hi", hi, 32'h1234);
        chk("mtlo_busy", {31'b0, busy}, 32'h0);

        issue(OP_MTHI, 32'hA, 32'h0);
        issue(OP_MTLO, 32'hB, 32'h0);
        issue(OP_DIVU, 32'd5, 32'd0);
        wait_done(cyc);
        chk("div0_cyc", cyc, 32'd10);
        chk("div0_hi", hi, 32'hA);
        chk("div0_lo", lo, 32'hB);

        issue(4'hF, 32'h77, 32'h77);
        chk("bad_busy", {31'b0, busy}, 32'h0);
        chk("bad_hi", hi, 32'hA);
        chk("bad_lo", lo, 32'hB);

        issue(OP_MULT, 32'd3, 32'd4);
        issue(OP_MTHI, 32'hDEAD, 32'h0);
        chk("mthi_busy_hi", hi, 32'hA);
        wait_done(cyc);
        chk("m34_cyc", cyc, 32'd4);
        chk("m34_hi", hi, 32'h0);
        chk("m34_lo", lo, 32'd12);

        // Abort in the third busy cycle.
        issue(OP_MULT, 32'd5, 32'd6);
        tick();
        tick();
        chk("abort_pre", {31'b0, busy}, 32'h1);
        reset = 1'b0;
        tick();
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);

        issue(OP_MULT, 32'd9, 32'd9);
        chk("rstwin_busy", {31'b0, busy}, 32'h0);
        chk("rstwin_lo", lo, 32'h0);
        reset = 1'b1;

        issue(OP_MULT, 32'd7, 32'd8);
        wait_done(cyc);
        chk("post_cyc", cyc, 32'd5);
        chk("post_lo", lo, 32'd56);
        chk("post_hi", hi, 32'h0);

        issue(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
        wait_done(cyc);
        chk("b2b_cyc", cyc, 32'd5);
        chk("b2b_hi", hi, 32'h0);
        chk("b2b_lo", lo, 32'd15);

        issue(OP_MTHI, 32'h0, 32'h0);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
        issue(OP_MADDU, 32'd1, 32'd1);
        wait_done(cyc);
`ifdef MDU_MADD_EN
        chk("maddu_cyc", cyc, 32'd5);
        chk("maddu_hi", hi, 32'h1);
        chk("maddu_lo", lo, 32'h0);
        issue(OP_MSUB, 32'hFFFF_FFFF, 32'd1);
        wait_done(cyc);
        chk("msub_cyc", cyc, 32'd5);
        chk("msub_hi", hi, 32'h1);
        chk("msub_lo", lo, 32'h1);
`else
        chk("maddu_cyc", cyc, 32'd0);
        chk("maddu_hi", hi, 32'h0);
        chk("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
